hall_call_dispatcher: RTL and testbench

Two-car hall-call dispatcher for the 7-floor lift system. It latches raw hall up/down presses and assigns each pending call to the nearer of two `liftcontroller` cars by driving that car's `up_button`/`down_button` vector. It holds each call until the serving car's `reset_up`/`reset_down` acknowledge arrives. It sits between the hall panels and two lift controller instances; car-internal buttons bypass it.

---
 rtl/hall_call_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher
//   Two-car hall-call dispatcher. Raw hall up/down presses are edge-detected
//   into pending registers. A three-state scanner (IDLE/PICK/ASSIGN) then
//   hands each pending call to the nearer available car, with car A winning
//   ties. Each assigned call is held on that car's button vector until the
//   car's service acknowledge clears it.
//
// Ports
//   clk                          system clock, rising edge
//   start                        asynchronous active-high reset
//   hall_up / hall_down          raw hall buttons (top up / bottom down unused)
//   floor_a / floor_b            one-hot present floor of each car
//   done_up_a .. done_down_b     per-car service acknowledges (bit clears)
//   up_button_a .. down_button_b registered calls assigned to each car
//   hall_up_lamp/hall_down_lamp  call registered (pending or assigned)
//   busy                         scanner in PICK or ASSIGN
module hall_call_dispatcher #(
   parameter int FLOORS = 7
) (
   input  logic              clk,
   input  logic              start,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_down,
   input  logic [FLOORS-1:0] floor_a,
   input  logic [FLOORS-1:0] floor_b,
   input  logic [FLOORS-1:0] done_up_a,
   input  logic [FLOORS-1:0] done_down_a,
   input  logic [FLOORS-1:0] done_up_b,
   input  logic [FLOORS-1:0] done_down_b,
   output logic [FLOORS-1:0] up_button_a,
   output logic [FLOORS-1:0] down_button_a,
   output logic [FLOORS-1:0] up_button_b,
   output logic [FLOORS-1:0] down_button_b,
   output logic [FLOORS-1:0] hall_up_lamp,
   output logic [FLOORS-1:0] hall_down_lamp,
   output logic              busy
);
   localparam int IW = (FLOORS > 2) ? $clog2(FLOORS) : 1;

   // No up call from the top floor, no down call from the bottom floor.
   localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_PICK, S_ASSIGN} state_t;
   state_t state, state_nxt;

   logic [FLOORS-1:0] prev_up, prev_down, pend_up, pend_down;
   logic [FLOORS-1:0] press_up, press_down;
   logic              lat_dir;        // 0 = up call, 1 = down call
   logic              lat_car;        // 0 = car A,   1 = car B
   logic [IW-1:0]     lat_floor;
   logic [FLOORS-1:0] lat_mask;
   logic [FLOORS-1:0] asg_up_a, asg_up_b, asg_down_a, asg_down_b;
   logic              found, pick_dir;
   logic [IW-1:0]     pick_floor;
   logic              avail_a, avail_b, take_b, go;
   logic [IW-1:0]     idx_a, idx_b, dist_a, dist_b;

   function automatic logic onehot(input logic [FLOORS-1:0] v);
      return (v != '0) && ((v & (v - FLOORS'(1))) == '0);
   endfunction

   function automatic logic [IW-1:0] enc(input logic [FLOORS-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < FLOORS; i++)
         if (v[i]) r = IW'(i);
      return r;
   endfunction

   function automatic logic [IW-1:0] absdiff(input logic [IW-1:0] a, input logic [IW-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   assign hall_up_lamp   = pend_up   | up_button_a   | up_button_b;
   assign hall_down_lamp = pend_down | down_button_a | down_button_b;

   // A lit lamp masks the press, so a call already in the system is never
   // re-queued (including the bit being assigned this cycle).
   assign press_up   = hall_up   & ~prev_up   & ~hall_up_lamp   & UP_OK;
   assign press_down = hall_down & ~prev_down & ~hall_down_lamp & DN_OK;

   // First pending call: up[0..], then down[1..].
   always_comb begin
      found      = 1'b0;
      pick_dir   = 1'b0;
      pick_floor = '0;
      for (int i = 0; i < FLOORS; i++)
         if (!found && pend_up[i]) begin
            found      = 1'b1;
            pick_floor = IW'(i);
         end
      for (int i = 0; i < FLOORS; i++)
         if (!found && pend_down[i]) begin
            found      = 1'b1;
            pick_dir   = 1'b1;
            pick_floor = IW'(i);
         end
   end

   assign avail_a = onehot(floor_a);
   assign avail_b = onehot(floor_b);
   assign idx_a   = enc(floor_a);
   assign idx_b   = enc(floor_b);
   assign dist_a  = absdiff(idx_a, pick_floor);
   assign dist_b  = absdiff(idx_b, pick_floor);
   // B only when strictly nearer or A is unavailable.
   assign take_b  = avail_b && (!avail_a || (dist_b < dist_a));
   assign go      = found && (avail_a || avail_b);

   // State register
   always_ff @(posedge clk or posedge start) begin
      if (start) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if ((pend_up | pend_down) != '0) state_nxt = S_PICK;
         S_PICK:   state_nxt = go ? S_ASSIGN : S_IDLE;
         S_ASSIGN: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign lat_mask = FLOORS'(1) << lat_floor;

   // Outputs of the scanner: busy flag and the one-hot assignment strobe
   always_comb begin
      busy       = 1'b0;
      asg_up_a   = '0;
      asg_up_b   = '0;
      asg_down_a = '0;
      asg_down_b = '0;
      case (state)
         S_PICK: busy = 1'b1;
         S_ASSIGN: begin
            busy = 1'b1;
            case ({lat_dir, lat_car})
               2'b00:   asg_up_a   = lat_mask;
               2'b01:   asg_up_b   = lat_mask;
               2'b10:   asg_down_a = lat_mask;
               default: asg_down_b = lat_mask;
            endcase
         end
         default: ;
      endcase
   end

   // Datapath. Clear is applied after set so an acknowledge landing on the
   // assignment cycle wins; pending is still dropped, the call is served.
   always_ff @(posedge clk or posedge start) begin
      if (start) begin
         prev_up       <= '0;
         prev_down     <= '0;
         pend_up       <= '0;
         pend_down     <= '0;
         up_button_a   <= '0;
         up_button_b   <= '0;
         down_button_a <= '0;
         down_button_b <= '0;
         lat_dir       <= 1'b0;
         lat_car       <= 1'b0;
         lat_floor     <= '0;
      end else begin
         prev_up       <= hall_up;
         prev_down     <= hall_down;
         pend_up       <= (pend_up   | press_up)   & ~(asg_up_a   | asg_up_b);
         pend_down     <= (pend_down | press_down) & ~(asg_down_a | asg_down_b);
         up_button_a   <= (up_button_a   | asg_up_a)   & ~done_up_a;
         up_button_b   <= (up_button_b   | asg_up_b)   & ~done_up_b;
         down_button_a <= (down_button_a | asg_down_a) & ~done_down_a;
         down_button_b <= (down_button_b | asg_down_b) & ~done_down_b;
         // Floors are only looked at here; later car moves don't redirect.
         if (state == S_PICK && go) begin
            lat_dir   <= pick_dir;
            lat_car   <= take_b;
            lat_floor <= pick_floor;
         end
      end
   end
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher: directed vector table, hand sequences for
// reset / multi-call / clear / unavailable corners, and a random run checked
// against an array-based reference model.
module tb_hall_call_dispatcher;
   localparam int F = 7;

   logic         clk = 1'b0;
   logic         start;
   logic [F-1:0] hall_up, hall_down, floor_a, floor_b;
   logic [F-1:0] done_up_a, done_down_a, done_up_b, done_down_b;
   logic [F-1:0] up_button_a, down_button_a, up_button_b, down_button_b;
   logic [F-1:0] hall_up_lamp, hall_down_lamp;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hall_call_dispatcher #(.FLOORS(F)) dut (
      .clk(clk), .start(start),
      .hall_up(hall_up), .hall_down(hall_down),
      .floor_a(floor_a), .floor_b(floor_b),
      .done_up_a(done_up_a), .done_down_a(done_down_a),
      .done_up_b(done_up_b), .done_down_b(done_down_b),
      .up_button_a(up_button_a), .down_button_a(down_button_a),
      .up_button_b(up_button_b), .down_button_b(down_button_b),
      .hall_up_lamp(hall_up_lamp), .hall_down_lamp(hall_down_lamp),
      .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] dut_outs();
      return {21'd0, busy, up_button_a, up_button_b, down_button_a, down_button_b,
              hall_up_lamp, hall_down_lamp};
   endfunction

   task automatic idle_inputs();
      hall_up = '0; hall_down = '0;
      done_up_a = '0; done_down_a = '0; done_up_b = '0; done_down_b = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves us on a negedge with start just released.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // ---------------- reference model ----------------
   bit m_pu[F], m_pd[F], m_prevu[F], m_prevd[F];
   bit m_btn[2][2][F];            // [car A/B][dir up/down][floor]
   int m_phase;                   // 0 idle, 1 choosing, 2 handing over
   int m_car, m_dir, m_fl;

   function automatic int car_floor(input logic [F-1:0] v);
      int n = 0, f = -1;
      for (int i = 0; i < F; i++) if (v[i]) begin n++; f = i; end
      return (n == 1) ? f : -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < F; i++) begin
         m_pu[i] = 0; m_pd[i] = 0; m_prevu[i] = 0; m_prevd[i] = 0;
         for (int c = 0; c < 2; c++) for (int d = 0; d < 2; d++) m_btn[c][d][i] = 0;
      end
      m_phase = 0; m_car = 0; m_dir = 0; m_fl = 0;
   endtask

   task automatic model_step();
      bit npu[F], npd[F];
      bit nbtn[2][2][F];
      int nphase, ca, cb, call_fl, call_dir, da, db;
      bit lu, ld, any;
      nbtn = m_btn;
      nphase = m_phase;
      any = 0;
      for (int i = 0; i < F; i++) begin
         lu = m_pu[i] | m_btn[0][0][i] | m_btn[1][0][i];
         ld = m_pd[i] | m_btn[0][1][i] | m_btn[1][1][i];
         npu[i] = m_pu[i] || (i < F-1 && hall_up[i]   && !m_prevu[i] && !lu);
         npd[i] = m_pd[i] || (i > 0   && hall_down[i] && !m_prevd[i] && !ld);
         any |= m_pu[i] | m_pd[i];
      end
      case (m_phase)
         0: if (any) nphase = 1;
         1: begin
            call_fl = -1; call_dir = 0;
            for (int i = F-1; i >= 0; i--) if (m_pd[i]) begin call_fl = i; call_dir = 1; end
            for (int i = F-1; i >= 0; i--) if (m_pu[i]) begin call_fl = i; call_dir = 0; end
            ca = car_floor(floor_a);
            cb = car_floor(floor_b);
            if (call_fl >= 0 && (ca >= 0 || cb >= 0)) begin
               da = (ca > call_fl) ? ca - call_fl : call_fl - ca;
               db = (cb > call_fl) ? cb - call_fl : call_fl - cb;
               m_car = (ca >= 0 && (cb < 0 || da <= db)) ? 0 : 1;
               m_dir = call_dir;
               m_fl  = call_fl;
               nphase = 2;
            end else nphase = 0;
         end
         default: begin
            nbtn[m_car][m_dir][m_fl] = 1;
            if (m_dir == 0) npu[m_fl] = 0; else npd[m_fl] = 0;
            nphase = 0;
         end
      endcase
      for (int i = 0; i < F; i++) begin
         if (done_up_a[i])   nbtn[0][0][i] = 0;
         if (done_down_a[i]) nbtn[0][1][i] = 0;
         if (done_up_b[i])   nbtn[1][0][i] = 0;
         if (done_down_b[i]) nbtn[1][1][i] = 0;
         m_prevu[i] = hall_up[i];
         m_prevd[i] = hall_down[i];
      end
      m_pu = npu; m_pd = npd; m_btn = nbtn; m_phase = nphase;
   endtask

   function automatic logic [63:0] model_outs();
      logic [F-1:0] ua, ub, da, db, lu, ld;
      for (int i = 0; i < F; i++) begin
         ua[i] = m_btn[0][0][i]; ub[i] = m_btn[1][0][i];
         da[i] = m_btn[0][1][i]; db[i] = m_btn[1][1][i];
         lu[i] = m_pu[i] | ua[i] | ub[i];
         ld[i] = m_pd[i] | da[i] | db[i];
      end
      return {21'd0, (m_phase != 0), ua, ub, da, db, lu, ld};
   endfunction

   function automatic logic [F-1:0] rnd_floor();
      int r;
      logic [F-1:0] v;
      r = $urandom_range(0, 9);
      if (r < 8)       v = F'(1) << $urandom_range(0, F-1);
      else if (r == 8) v = '0;
      else             v = F'($urandom) | F'(3);
      return v;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [F-1:0] fa, fb, up, dn;   // car floors, single-cycle press
      logic [F-1:0] lu, ld;           // lamps after the sampling edge
      logic [F-1:0] ua, ub, da, db;   // car outputs three edges later
   } vec_t;
   vec_t vt[10];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [F-1:0] ticked;
      int nb;
      bit seen;

      vt[0] = '{7'b0000010, 7'b0100000, 7'b0010000, 7'b0000000, 7'b0010000, 7'b0000000, 7'b0000000, 7'b0010000, 7'b0000000, 7'b0000000};
      vt[1] = '{7'b0000100, 7'b0010000, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0000000, 7'b0001000, 7'b0000000};
      vt[2] = '{7'b0000001, 7'b1000000, 7'b0000001, 7'b0000000, 7'b0000001, 7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000};
      vt[3] = '{7'b0000001, 7'b1000000, 7'b0000000, 7'b1000000, 7'b0000000, 7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1000000};
      vt[4] = '{7'b0000011, 7'b0000100, 7'b0100000, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000};
      vt[5] = '{7'b0001000, 7'b0000000, 7'b0000000, 7'b0000010, 7'b0000000, 7'b0000010, 7'b0000000, 7'b0000000, 7'b0000010, 7'b0000000};
      vt[6] = '{7'b1000000, 7'b0000001, 7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000};
      vt[7] = '{7'b0000010, 7'b0000100, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000};
      vt[8] = '{7'b0000001, 7'b0000010, 7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
      vt[9] = '{7'b0000001, 7'b0000010, 7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

      start = 1'b1;
      idle_inputs();
      floor_a = '0; floor_b = '0;
      #2;
      check("reset_state", dut_outs(), 64'd0);

      // ---- table ----
      for (int k = 0; k < 10; k++) begin
         do_reset();
         floor_a = vt[k].fa; floor_b = vt[k].fb;
         hall_up = vt[k].up; hall_down = vt[k].dn;
         tick(1);                                   // E0
         hall_up = '0; hall_down = '0;
         check($sformatf("vec%0d_lamp", k), {50'd0, hall_up_lamp, hall_down_lamp}, {50'd0, vt[k].lu, vt[k].ld});
         tick(2);                                   // E2: not yet assigned
         check($sformatf("vec%0d_early", k), {36'd0, up_button_a, up_button_b, down_button_a, down_button_b}, 64'd0);
         tick(1);                                   // E3
         check($sformatf("vec%0d_assign", k), {36'd0, up_button_a, up_button_b, down_button_a, down_button_b},
               {36'd0, vt[k].ua, vt[k].ub, vt[k].da, vt[k].db});
      end

      // ---- reset during ASSIGN, button held through reset ----
      do_reset();
      floor_a = 7'b0000001; floor_b = 7'b0001000;
      hall_up = 7'b0001000;
      tick(1); hall_up = '0;
      tick(3);
      check("rst_setup_upb3", {57'd0, up_button_b}, {57'd0, 7'b0001000});
      hall_down = 7'b0100000;
      tick(1); hall_down = '0;
      tick(2);                                      // now in ASSIGN
      check("rst_setup_busy", {63'd0, busy}, 64'd1);
      #1 start = 1'b1; hall_up = 7'b0000100;
      #1 check("rst_async_outs", dut_outs(), 64'd0);
      @(negedge clk); start = 1'b0;
      tick(1);
      check("rst_held_press", {57'd0, hall_up_lamp}, {57'd0, 7'b0000100});

      // ---- two simultaneous calls plus ignored invalid bits ----
      do_reset();
      floor_a = 7'b0000001; floor_b = 7'b1000000;
      hall_up = 7'b1000001; hall_down = 7'b1000001;
      tick(1); hall_up = '0; hall_down = '0;
      check("two_lamps", {50'd0, hall_up_lamp, hall_down_lamp}, {50'd0, 7'b0000001, 7'b1000000});
      tick(2);
      check("two_busy_e2", {63'd0, busy}, 64'd1);
      tick(1);                                      // E3
      check("two_e3", {50'd0, up_button_a, down_button_b}, {50'd0, 7'b0000001, 7'b0000000});
      tick(3);                                      // E6
      check("two_e6", {36'd0, up_button_a, up_button_b, down_button_a, down_button_b},
            {36'd0, 7'b0000001, 7'b0000000, 7'b0000000, 7'b1000000});

      // ---- re-press on a lamped call is ignored, then service clear ----
      hall_up = 7'b0000001;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         hall_up = '0;
         seen |= busy;
      end
      check("repress_busy", {63'd0, seen}, 64'd0);
      check("repress_state", {50'd0, up_button_a, hall_up_lamp}, {50'd0, 7'b0000001, 7'b0000001});
      done_up_a = 7'b0000001;
      tick(1); done_up_a = '0;
      check("clear_upa0", {50'd0, up_button_a, hall_up_lamp}, 64'd0);
      check("clear_keeps_db6", {57'd0, down_button_b}, {57'd0, 7'b1000000});

      // ---- clear arriving on the assignment edge wins ----
      floor_a = 7'b0000100;
      hall_up = 7'b0000100;
      tick(1); hall_up = '0;
      tick(2);
      done_up_a = 7'b0000100;
      tick(1); done_up_a = '0;                      // E3
      check("clearwin_e3", {50'd0, up_button_a, hall_up_lamp}, 64'd0);
      tick(3);
      check("clearwin_after", {56'd0, busy, up_button_a}, 64'd0);

      // ---- both cars unavailable, then car B becomes usable ----
      do_reset();
      floor_a = '0; floor_b = 7'b0011000;
      hall_up = 7'b0000010;
      tick(1); hall_up = '0;
      check("unav_lamp", {57'd0, hall_up_lamp}, {57'd0, 7'b0000010});
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (busy) nb++;
      end
      check("unav_busy_cnt", 64'(nb), 64'd3);
      check("unav_no_assign", {21'd0, 1'b0, up_button_a, up_button_b, down_button_a, down_button_b, hall_up_lamp, 7'b0},
            {21'd0, 1'b0, 28'd0, 7'b0000010, 7'b0});
      floor_b = 7'b0001000;
      seen = 0;
      for (int i = 0; i < 3 && !seen; i++) begin
         tick(1);
         if (up_button_b[1]) seen = 1;
      end
      check("unav_retry_assign", {63'd0, seen}, 64'd1);

      // ---- random run against the model ----
      do_reset();
      model_reset();
      floor_a = rnd_floor(); floor_b = rnd_floor();
      for (int c = 0; c < 3000; c++) begin
         check("rand", dut_outs(), model_outs());
         ticked = F'($urandom);
         hall_up   = F'($urandom) & F'($urandom) & ticked;
         hall_down = F'($urandom) & F'($urandom) & ~ticked;
         done_up_a   = F'($urandom) & F'($urandom) & F'($urandom) & F'($urandom);
         done_down_a = F'($urandom) & F'($urandom) & F'($urandom) & F'($urandom);
         done_up_b   = F'($urandom) & F'($urandom) & F'($urandom) & F'($urandom);
         done_down_b = F'($urandom) & F'($urandom) & F'($urandom) & F'($urandom);
         if ($urandom_range(0, 7) == 0) floor_a = rnd_floor();
         if ($urandom_range(0, 7) == 0) floor_b = rnd_floor();
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
      check("rand_final", dut_outs(), model_outs());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
